ts_stream_generator: RTL

Single-clock MPEG-2 TS source that emits 188-byte transport packets as a byte stream with valid and sync strobes, in the same format the QoS input ports consume (byte + valid, sync on the 0x47 header byte). It is the transmit end of the QoS path: it feeds lab and testbench stimulus into one `wclkN/validN/ts_dataN` input. It is configured over the same 8-bit-address / 32-bit-data memory-mapped interface as the main control block.

---
 rtl/ts_gen_pkg.sv | 20 ++
 rtl/ts_gen_regs.sv | 119 +++++++++++
 rtl/ts_stream_generator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ts_gen_pkg.sv
// Shared definitions for the TS stream generator: fixed header constants, register
// byte addresses and the FSM state encoding.
package ts_gen_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'h47;
  localparam int unsigned HDR_LEN   = 4;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_PID     = 8'h04;
  localparam logic [7:0] ADDR_GAP     = 8'h08;
  localparam logic [7:0] ADDR_PKT_CNT = 8'h0C;
  localparam logic [7:0] ADDR_ERR_INJ = 8'h10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    PACE = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_gen_regs.sv
// Register file for the TS stream generator.
// Holds CTRL/PID/GAP, the completed-packet counter and (with TS_ERR_INJECT_EN defined)
// the one-shot error-injection pending bits. Reads are registered and hold between reads.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mm_write_en/mm_read_en     bus strobes
//   mm_addr, mm_wdata          bus address / write data
//   mm_rdata                   registered read data
//   pkt_done                   last byte of a packet is being emitted
//   pkt_start                  byte 0 of a packet is being emitted (consumes pending errors)
//   enable, pay_mode, pid, gap live configuration
//   inj_cc_skip, inj_bad_sync  pending injection bits (tied 0 without TS_ERR_INJECT_EN)
module ts_gen_regs #(
  parameter logic [12:0] DEFAULT_PID = 13'h0100,
  parameter logic [7:0]  DEFAULT_GAP = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mm_write_en,
  input  logic        mm_read_en,
  input  logic [7:0]  mm_addr,
  input  logic [31:0] mm_wdata,
  output logic [31:0] mm_rdata,
  input  logic        pkt_done,
  input  logic        pkt_start,
  output logic        enable,
  output logic        pay_mode,
  output logic [12:0] pid,
  output logic [7:0]  gap,
  output logic        inj_cc_skip,
  output logic        inj_bad_sync
);
  import ts_gen_pkg::*;

  logic [1:0]  ctrl_q;
  logic [12:0] pid_q;
  logic [7:0]  gap_q;
  logic [31:0] cnt_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_mux;
  logic        en_rise;
  logic        unused_wdata;

  assign unused_wdata = ^mm_wdata[31:13];

  // Counter restarts whenever software turns the generator on from off.
  assign en_rise = mm_write_en && (mm_addr == ADDR_CTRL) && mm_wdata[0] && !ctrl_q[0];

`ifdef TS_ERR_INJECT_EN
  logic [1:0] inj_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_q <= 2'b00;
    end else if (mm_write_en && (mm_addr == ADDR_ERR_INJ)) begin
      inj_q <= mm_wdata[1:0];
    end else if (pkt_start) begin
      inj_q <= 2'b00;
    end
  end

  assign inj_cc_skip  = inj_q[0];
  assign inj_bad_sync = inj_q[1];
`else
  logic unused_pkt_start;
  assign unused_pkt_start = pkt_start;
  assign inj_cc_skip      = 1'b0;
  assign inj_bad_sync     = 1'b0;
`endif

  always_comb begin
    rdata_mux = 32'd0;
    case (mm_addr)
      ADDR_CTRL:    rdata_mux = {30'd0, ctrl_q};
      ADDR_PID:     rdata_mux = {19'd0, pid_q};
      ADDR_GAP:     rdata_mux = {24'd0, gap_q};
      ADDR_PKT_CNT: rdata_mux = cnt_q;
`ifdef TS_ERR_INJECT_EN
      ADDR_ERR_INJ: rdata_mux = {30'd0, inj_q};
`endif
      default:      rdata_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= 2'b00;
      pid_q   <= DEFAULT_PID;
      gap_q   <= DEFAULT_GAP;
      cnt_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (mm_write_en) begin
        case (mm_addr)
          ADDR_CTRL: ctrl_q <= mm_wdata[1:0];
          ADDR_PID:  pid_q  <= mm_wdata[12:0];
          ADDR_GAP:  gap_q  <= mm_wdata[7:0];
          default:   ;
        endcase
      end
      if (en_rise) begin
        cnt_q <= {31'd0, pkt_done};
      end else if (pkt_done) begin
        cnt_q <= cnt_q + 32'd1;
      end
      // Mux sees pre-write values, so a same-cycle read returns the old contents.
      if (mm_read_en) begin
        rdata_q <= rdata_mux;
      end
    end
  end

  assign mm_rdata = rdata_q;
  assign enable   = ctrl_q[0];
  assign pay_mode = ctrl_q[1];
  assign pid      = pid_q;
  assign gap      = gap_q;

endmodule

// File: rtl/ts_stream_generator.sv
// MPEG-2 TS packet source: emits PKT_LEN-byte packets as a byte stream with valid/sync
// strobes, paced by a programmable idle gap, configured over an 8-bit-addr/32-bit-data bus.
// Optional error injection (register 0x10) is compiled in with TS_ERR_INJECT_EN.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   mm_write_en, mm_read_en       bus strobes
//   mm_addr, mm_wdata, mm_rdata   bus address, write data, registered read data
//   valid_out, sync_out           byte strobe, header-byte-0 strobe
//   ts_data_out                   stream byte
//   busy                          packet in progress
module ts_stream_generator #(
  parameter int unsigned PKT_LEN     = 188,
  parameter logic [12:0] DEFAULT_PID = 13'h0100,
  parameter logic [7:0]  DEFAULT_GAP = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mm_write_en,
  input  logic        mm_read_en,
  input  logic [7:0]  mm_addr,
  input  logic [31:0] mm_wdata,
  output logic [31:0] mm_rdata,
  output logic        valid_out,
  output logic        sync_out,
  output logic [7:0]  ts_data_out,
  output logic        busy
);
  import ts_gen_pkg::*;

  localparam int unsigned IW = $clog2(PKT_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

  logic        enable, pay_mode, inj_cc_skip, inj_bad_sync;
  logic [12:0] pid;
  logic [7:0]  gap;
  logic        pkt_done, pkt_start, emit;

  ts_state_e   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, nxt, off;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [3:0]  cc_q, cc_d;
  logic [12:0] pid_sh_q, pid_sh_d;
  logic [7:0]  gap_sh_q, gap_sh_d;
  logic        pay_sh_q, pay_sh_d;
  logic        valid_q, valid_d, sync_q, sync_d, busy_q, busy_d;
  logic [7:0]  data_q, data_d;

  ts_gen_regs #(
    .DEFAULT_PID (DEFAULT_PID),
    .DEFAULT_GAP (DEFAULT_GAP)
  ) u_regs (
    .clk          (clk),
    .rst_n        (rst_n),
    .mm_write_en  (mm_write_en),
    .mm_read_en   (mm_read_en),
    .mm_addr      (mm_addr),
    .mm_wdata     (mm_wdata),
    .mm_rdata     (mm_rdata),
    .pkt_done     (pkt_done),
    .pkt_start    (pkt_start),
    .enable       (enable),
    .pay_mode     (pay_mode),
    .pid          (pid),
    .gap          (gap),
    .inj_cc_skip  (inj_cc_skip),
    .inj_bad_sync (inj_bad_sync)
  );

  // Byte index that the current edge would present if it emits.
  assign nxt = ((state_q == IDLE) || (idx_q == LAST_IDX)) ? '0 : idx_q + IW'(1);
  assign off = nxt - IW'(HDR_LEN);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    cc_d      = cc_q;
    pid_sh_d  = pid_sh_q;
    gap_sh_d  = gap_sh_q;
    pay_sh_d  = pay_sh_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    sync_d    = 1'b0;
    data_d    = 8'd0;
    emit      = 1'b0;
    pkt_done  = 1'b0;
    pkt_start = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        emit   = enable;
      end
      EMIT: begin
        // Enable is only honoured at a packet boundary, so packets are never truncated.
        if ((idx_q == LAST_IDX) && !enable) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (gap_sh_q != 8'd0) begin
          state_d   = PACE;
          gap_cnt_d = gap_sh_q;
        end else begin
          emit = 1'b1;
        end
      end
      PACE: begin
        if (gap_cnt_q <= 8'd1) begin
          emit = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      state_d = EMIT;
      busy_d  = 1'b1;
      valid_d = 1'b1;
      idx_d   = nxt;
      if (nxt == '0) begin
        // Configuration is sampled once per packet so mid-packet writes wait a packet.
        pkt_start = 1'b1;
        pid_sh_d  = pid;
        gap_sh_d  = gap;
        pay_sh_d  = pay_mode;
        sync_d    = 1'b1;
        data_d    = inj_bad_sync ? 8'h00 : SYNC_BYTE;
        if (inj_cc_skip) begin
          cc_d = cc_q + 4'd1;
        end
      end else if (nxt == IW'(1)) begin
        data_d = {3'b000, pid_sh_q[12:8]};
      end else if (nxt == IW'(2)) begin
        data_d = pid_sh_q[7:0];
      end else if (nxt == IW'(3)) begin
        data_d = {4'b0001, cc_q};
      end else begin
        data_d = pay_sh_q ? 8'hFF : 8'(off);
      end
      if (nxt == LAST_IDX) begin
        pkt_done = 1'b1;
        cc_d     = cc_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gap_cnt_q <= 8'd0;
      cc_q      <= 4'd0;
      pid_sh_q  <= DEFAULT_PID;
      gap_sh_q  <= DEFAULT_GAP;
      pay_sh_q  <= 1'b0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      data_q    <= 8'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      cc_q      <= cc_d;
      pid_sh_q  <= pid_sh_d;
      gap_sh_q  <= gap_sh_d;
      pay_sh_q  <= pay_sh_d;
      valid_q   <= valid_d;
      sync_q    <= sync_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  assign valid_out   = valid_q;
  assign sync_out    = sync_q;
  assign ts_data_out = data_q;
  assign busy        = busy_q;

endmodule
